// File: rtl/prog_fetch_pkg.sv
// prog_fetch_pkg: shared defaults and types for the instruction-fetch stage.
//   ADDR_W_DEF / DATA_W_DEF   : default program address / instruction widths
//   STK_DEPTH_DEF             : default return-address stack depth
//   RST_VEC_DEF / INTR_VEC_DEF: reset and interrupt fetch addresses
//   next_sel_t                : source selector for the next fetch address
package prog_fetch_pkg;

  localparam int unsigned ADDR_W_DEF    = 10;
  localparam int unsigned DATA_W_DEF    = 18;
  localparam int unsigned STK_DEPTH_DEF = 8;
  localparam logic [9:0]  RST_VEC_DEF   = 10'h000;
  localparam logic [9:0]  INTR_VEC_DEF  = 10'h3FF;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_INTR
  } next_sel_t;

endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: LIFO of return addresses for the fetch unit.
//   clk, rst_n : clock, synchronous active-low reset (empties the stack)
//   push       : write push_data on top (ignored when full)
//   pop        : discard top entry (ignored when empty)
//   push_data  : address to push
//   top        : most recently pushed entry (meaningless when empty)
//   empty/full : occupancy status
module ret_addr_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW:0]    cnt_q;
  logic [PtrW-1:0]  sp;

  // Low bits of the count index the next free slot; when full they wrap to 0,
  // so sp-1 still addresses the top entry.
  assign sp    = cnt_q[PtrW-1:0];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PtrW+1)'(DEPTH));
  assign top   = mem[sp - 1'b1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp] <= push_data;
    end
  end

endmodule

// File: rtl/prog_fetch_unit.sv
// prog_fetch_unit: instruction-fetch stage in front of a registered program ROM.
//   CLK, RST_N       : clock, synchronous active-low reset
//   STALL            : hold the current instruction
//   JMP, CALL, RET   : redirect requests (RET > CALL > JMP)
//   JMP_ADDR         : jump / call target
//   PROG_ADDR        : combinational ROM address (next fetch)
//   PROG_IR          : ROM data for the previous PROG_ADDR
//   IR, IR_PC        : current instruction and its address
//   IR_VALID         : IR / IR_PC meaningful
//   STK_OVF, STK_UNF : sticky stack overflow / underflow flags
// Optional macro PROG_FETCH_INTR_VEC_EN adds INTR (top-priority vectored
// interrupt, pushes the interrupted pc) and INTR_ACK (1-cycle registered pulse).
module prog_fetch_unit
  import prog_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W    = ADDR_W_DEF,
  parameter int unsigned        DATA_W    = DATA_W_DEF,
  parameter int unsigned        STK_DEPTH = STK_DEPTH_DEF,
  parameter logic [ADDR_W-1:0]  RST_VEC   = ADDR_W'(RST_VEC_DEF),
  parameter logic [ADDR_W-1:0]  INTR_VEC  = ADDR_W'(INTR_VEC_DEF)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic              JMP,
  input  logic              CALL,
  input  logic              RET,
`ifdef PROG_FETCH_INTR_VEC_EN
  input  logic              INTR,
  output logic              INTR_ACK,
`endif
  input  logic [ADDR_W-1:0] JMP_ADDR,
  output logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [DATA_W-1:0] PROG_IR,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] IR_PC,
  output logic              IR_VALID,
  output logic              STK_OVF,
  output logic              STK_UNF
);

  next_sel_t         sel;
  logic [ADDR_W-1:0] pc_q, pc_inc, next_pc, push_data, stk_top;
  logic              ir_valid_q, ovf_q, unf_q;
  logic              stk_push, stk_pop, stk_empty, stk_full, intr_req;

`ifdef PROG_FETCH_INTR_VEC_EN
  assign intr_req = INTR;
`else
  assign intr_req = 1'b0;
`endif

  assign pc_inc = pc_q + 1'b1;  // wraps modulo 2**ADDR_W

  always_comb begin
    sel = SEL_HOLD;
    if (ir_valid_q && !STALL) begin
      if (intr_req)  sel = SEL_INTR;
      else if (RET)  sel = SEL_RET;
      else if (CALL) sel = SEL_CALL;
      else if (JMP)  sel = SEL_JMP;
      else           sel = SEL_INC;
    end
  end

  always_comb begin
    next_pc = pc_q;
    unique case (sel)
      SEL_HOLD: next_pc = pc_q;
      SEL_INC:  next_pc = pc_inc;
      SEL_JMP,
      SEL_CALL: next_pc = JMP_ADDR;
      SEL_RET:  next_pc = stk_empty ? pc_inc : stk_top;
      SEL_INTR: next_pc = INTR_VEC;
      default:  next_pc = pc_q;
    endcase
  end

  // Interrupts push the interrupted pc so it is re-fetched on return.
  assign push_data = (sel == SEL_INTR) ? pc_q : pc_inc;
  assign stk_push  = ((sel == SEL_CALL) || (sel == SEL_INTR)) && !stk_full;
  assign stk_pop   = (sel == SEL_RET) && !stk_empty;

  assign PROG_ADDR = RST_N ? next_pc : RST_VEC;
  assign IR        = PROG_IR;
  assign IR_PC     = pc_q;
  assign IR_VALID  = ir_valid_q;
  assign STK_OVF   = ovf_q;
  assign STK_UNF   = unf_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q       <= RST_VEC;
      ir_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      ir_valid_q <= 1'b1;
      if (((sel == SEL_CALL) || (sel == SEL_INTR)) && stk_full) ovf_q <= 1'b1;
      if ((sel == SEL_RET) && stk_empty)                         unf_q <= 1'b1;
    end
  end

`ifdef PROG_FETCH_INTR_VEC_EN
  logic intr_ack_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) intr_ack_q <= 1'b0;
    else        intr_ack_q <= (sel == SEL_INTR);
  end
  assign INTR_ACK = intr_ack_q;
`endif

  ret_addr_stack #(
    .DEPTH (STK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (push_data),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full)
  );

endmodule

// File: tb/tb_prog_fetch_unit.sv
// tb_prog_fetch_unit: directed + randomized bench for prog_fetch_unit with a
// behavioural ROM and a queue-based reference model of the fetch rules.
module tb_prog_fetch_unit;

  localparam int DEPTH    = 8;
  localparam int ROM_SZ   = 1024;
  localparam int RST_VEC  = 0;
  localparam int INTR_VEC = 'h3FF;

  logic        CLK = 1'b0;
  logic        RST_N, STALL, JMP, CALL, RET;
  logic [9:0]  JMP_ADDR, PROG_ADDR, IR_PC;
  logic [17:0] PROG_IR, IR;
  logic        IR_VALID, STK_OVF, STK_UNF;
`ifdef PROG_FETCH_INTR_VEC_EN
  logic        INTR, INTR_ACK;
`endif

  logic [17:0] rom [ROM_SZ];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  m_pc;
  bit  m_valid, m_ovf, m_unf, m_ack;
  int  stk[$];

  prog_fetch_unit dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .STALL     (STALL),
    .JMP       (JMP),
    .CALL      (CALL),
    .RET       (RET),
`ifdef PROG_FETCH_INTR_VEC_EN
    .INTR      (INTR),
    .INTR_ACK  (INTR_ACK),
`endif
    .JMP_ADDR  (JMP_ADDR),
    .PROG_ADDR (PROG_ADDR),
    .PROG_IR   (PROG_IR),
    .IR        (IR),
    .IR_PC     (IR_PC),
    .IR_VALID  (IR_VALID),
    .STK_OVF   (STK_OVF),
    .STK_UNF   (STK_UNF)
  );

  always #5 CLK = ~CLK;

  // Registered ROM read
  always @(posedge CLK) PROG_IR <= rom[PROG_ADDR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      RST_N    = 1'b0;
      STALL    = 1'($urandom);
      JMP      = 1'($urandom);
      CALL     = 1'($urandom);
      RET      = 1'($urandom);
      JMP_ADDR = 10'($urandom);
`ifdef PROG_FETCH_INTR_VEC_EN
      INTR     = 1'($urandom);
`endif
      #1;
      check("rst_prog_addr", PROG_ADDR, RST_VEC);
      @(posedge CLK);
      m_pc = RST_VEC; m_valid = 0; m_ovf = 0; m_unf = 0; m_ack = 0;
      stk.delete();
      @(negedge CLK);
    end
  endtask

  // One cycle: drive, check current state and next address, advance model.
  task automatic step(input bit stall, input bit jmp, input bit call, input bit ret,
                      input bit intr, input int addr);
    int exp_next;
    bit take_intr, acc;
    RST_N    = 1'b1;
    STALL    = stall;
    JMP      = jmp;
    CALL     = call;
    RET      = ret;
    JMP_ADDR = 10'(addr);
`ifdef PROG_FETCH_INTR_VEC_EN
    INTR      = intr;
    take_intr = intr;
`else
    take_intr = 1'b0;
`endif
    #1;
    check("ir_valid", IR_VALID, m_valid);
    check("ir_pc", IR_PC, m_pc);
    if (m_valid) check("ir", IR, rom[m_pc]);
    check("stk_ovf", STK_OVF, m_ovf);
    check("stk_unf", STK_UNF, m_unf);
`ifdef PROG_FETCH_INTR_VEC_EN
    check("intr_ack", INTR_ACK, m_ack);
`endif
    exp_next = m_pc;
    acc      = 0;
    if (m_valid && !stall) begin
      if (take_intr) begin
        if (stk.size() < DEPTH) stk.push_back(m_pc); else m_ovf = 1;
        exp_next = INTR_VEC;
        acc      = 1;
      end else if (ret) begin
        if (stk.size() > 0) exp_next = stk.pop_back();
        else begin
          exp_next = (m_pc + 1) % ROM_SZ;
          m_unf    = 1;
        end
      end else if (call) begin
        if (stk.size() < DEPTH) stk.push_back((m_pc + 1) % ROM_SZ); else m_ovf = 1;
        exp_next = addr % ROM_SZ;
      end else if (jmp) begin
        exp_next = addr % ROM_SZ;
      end else begin
        exp_next = (m_pc + 1) % ROM_SZ;
      end
    end
    check("prog_addr", PROG_ADDR, exp_next);
    @(posedge CLK);
    m_pc    = exp_next;
    m_valid = 1;
    m_ack   = acc;
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < ROM_SZ; i++) rom[i] = {8'($urandom), 10'(i)};
    RST_N = 1'b0; STALL = 0; JMP = 0; CALL = 0; RET = 0; JMP_ADDR = '0;
`ifdef PROG_FETCH_INTR_VEC_EN
    INTR = 0;
`endif
    @(negedge CLK);
    do_reset(3);

    // Release: one invalid cycle, then sequential 0,1,2,3,4
    step(0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);

    // Stall at 5 for three cycles
    repeat (3) step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Call 0x100 from 0x010, return from 0x102
    step(0, 1, 0, 0, 0, 'h010);
    step(0, 0, 1, 0, 0, 'h100);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Nine nested calls, then nine returns (last one underflows)
    repeat (9) step(0, 0, 1, 0, 0, int'($urandom_range(1023)));
    repeat (9) step(0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Address wrap 0x3FE -> 0x3FF -> 0x000
    step(0, 1, 0, 0, 0, 'h3FE);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // JMP and CALL together: CALL wins and pushes
    step(0, 1, 1, 0, 0, 'h055);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Reset mid-operation clears flags and stack
    do_reset(2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Interrupt at 0x020, later return
    step(0, 1, 0, 0, 0, 'h020);
    step(0, 0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) < 1) do_reset(1);
      else step($urandom_range(99) < 20, $urandom_range(99) < 15, $urandom_range(99) < 12,
                $urandom_range(99) < 12, $urandom_range(99) < 5,
                int'($urandom_range(1023)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_fetch_unit.md
Name: prog_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the 1024x18 program ROM.
- Owns the program counter and drives the ROM's 10-bit address combinationally.
- Tags the ROM's registered 18-bit output with its address and a valid bit, and passes it to the control/decode logic.
- Handles sequential fetch, stall, jump, call and return, using an internal hardware return-address stack.

Parameters:
- ADDR_W, 10, program address width (ROM depth = 2**ADDR_W)
- DATA_W, 18, instruction width
- STK_DEPTH, 8, return-address stack entries (power of two, >=2)
- RST_VEC, 0, address fetched out of reset
- INTR_VEC, 10'h3FF, interrupt vector (used only with the optional feature)

Ports:
- CLK  in  1  single clock, rising edge, shared with ROM PROG_CLK
- RST_N  in  1  synchronous, active-low reset
- STALL  in  1  hold current instruction; no redirect, no PC advance
- JMP  in  1  redirect to JMP_ADDR
- CALL  in  1  push return address, redirect to JMP_ADDR
- RET  in  1  pop stack, redirect to popped address
- JMP_ADDR  in  ADDR_W  jump/call target
- PROG_ADDR  out  ADDR_W  address to ROM (combinational)
- PROG_IR  in  DATA_W  ROM data, 1-cycle registered read of PROG_ADDR
- IR  out  DATA_W  current instruction (= PROG_IR)
- IR_PC  out  ADDR_W  address of IR
- IR_VALID  out  1  IR/IR_PC meaningful
- STK_OVF  out  1  sticky: CALL while stack full
- STK_UNF  out  1  sticky: RET while stack empty

Behaviour:
- The clock is CLK; reset is synchronous and active-low (RST_N). There is no asynchronous reset path.
- State:
  - pc_q: address whose data is on PROG_IR this cycle.
  - IR_VALID register.
  - Stack array, stack pointer and count.
  - STK_OVF, STK_UNF.
- Reset (RST_N=0 at edge):
  - pc_q = RST_VEC; IR_VALID = 0; stack count = 0; STK_OVF = STK_UNF = 0.
  - While RST_N=0, PROG_ADDR = RST_VEC.
- IR_VALID goes to 1 at the first edge with RST_N=1, so IR = rom[RST_VEC] in the following cycle. It then stays 1 until reset.
- IR = PROG_IR, IR_PC = pc_q (both combinational).
- next_pc / PROG_ADDR, evaluated each cycle:
  - If !IR_VALID or STALL: pc_q. The ROM re-reads the same word, so IR stays stable.
  - Otherwise, priority (high to low) is INTR*, RET, CALL, JMP, increment. Lower-priority requests asserted in the same cycle are ignored.
  - Increment: pc_q+1 modulo 2**ADDR_W (0x3FF wraps to 0x000).
- pc_q <= next_pc every non-reset edge.
- Redirect latency: a request in cycle t yields IR = rom[target] in cycle t+1. There are no bubbles and no flush.
- CALL:
  - Push pc_q+1 (wrapped), then redirect to JMP_ADDR.
  - If the stack is full: the push is dropped, STK_OVF is set, and the redirect still occurs.
- RET:
  - Pop the top entry; next_pc = popped value.
  - If the stack is empty: next_pc = pc_q+1, STK_UNF is set, and the count stays 0.
- Stack is LIFO. A CALL or RET that is ignored due to STALL, !IR_VALID or priority has no stack effect.
- Reset mid-operation discards all stack contents and the current fetch.

Optional Feature:
- Macro: PROG_FETCH_INTR_VEC_EN.
- When defined:
  - Adds input INTR (1) and output INTR_ACK (1).
  - INTR has top priority when IR_VALID && !STALL.
  - It pushes pc_q (the interrupted instruction is re-fetched on RET) and sets next_pc = INTR_VEC.
  - INTR_ACK is a registered 1-cycle pulse in the cycle after acceptance; reset value 0.
  - Overflow rules match CALL.
- When undefined: no INTR or INTR_ACK ports, and the priority list starts at RET.

Decomposition:
- Package prog_fetch_pkg:
  - ADDR_W/DATA_W defaults, RST_VEC, INTR_VEC.
  - Enum typedef next_sel_t {SEL_HOLD, SEL_INC, SEL_JMP, SEL_CALL, SEL_RET, SEL_INTR}.
- One sub-module, ret_addr_stack:
  - Parameters DEPTH and width.
  - Ports: push, pop, push_data, top, empty, full.
  - Synchronous, cleared by RST_N.

Test Plan:
- Reset then release with ROM[i]=i: IR_PC/IR read 0,1,2,3 on consecutive cycles; IR_VALID=0 only during reset and in the first release cycle.
- STALL high 3 cycles at IR_PC=5: IR_PC=5 and IR stable for 4 cycles, then 6.
- CALL JMP_ADDR=0x100 at IR_PC=0x010, then RET at 0x102: next IR_PC=0x100, ..., then 0x011; no flags.
- Nine nested CALLs with STK_DEPTH=8: STK_OVF=1 after the 9th. Nine RETs: 8 correct return addresses, then STK_UNF=1 and the fallthrough is pc+1.
- PC at 0x3FF with no redirect: next IR_PC=0x000. JMP+CALL same cycle: CALL wins (push occurs).
- With PROG_FETCH_INTR_VEC_EN, INTR at IR_PC=0x020: next IR_PC=0x3FF, INTR_ACK pulses once, and a later RET returns to 0x020.
